fpu_result_drain: RTL and testbench

// - Consumer end of the FPU result pipeline. It accepts float_point_num results from the

---
 rtl/fpu_result_drain_if.sv | 32 +++
 rtl/fpu_result_drain.sv | 82 ++++++++
 tb/tb_fpu_result_drain.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_result_drain_if.sv
// Handshake bundle between the FPU pipeline tail, the result drain and the
// downstream consumer. The producer/consumer side is the master, the drain
// itself is the slave.
interface fpu_result_drain_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic          in_valid;
  logic [31:0]   in_data;
  logic          pipe_en;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_is_zero;
  logic          out_is_inf;
  logic          out_is_nan;
  logic [CW-1:0] count;
  logic          ovf_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  pipe_en, out_valid, out_data, out_is_zero, out_is_inf, out_is_nan,
           count, ovf_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output pipe_en, out_valid, out_data, out_is_zero, out_is_inf, out_is_nan,
           count, ovf_err
  );
endinterface

// File: rtl/fpu_result_drain.sv
// Result drain at the tail of the FPU pipeline: a small FWFT FIFO that
// back-pressures the whole pipeline through pipe_en and classifies the
// head result as zero / infinity / NaN.
module fpu_result_drain #(
  parameter int DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  fpu_result_drain_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          ovf_reg;

  logic          out_valid;
  logic          pop;
  logic          pipe_en;
  logic          push;
  logic [31:0]   head;
  logic [7:0]    head_exp;
  logic [22:0]   head_mant;

  // Handshake decode. A pop frees a slot in the same cycle, so a full FIFO
  // being drained still lets the pipeline advance.
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid & bus.out_ready;
  assign pipe_en   = (count_reg < CW'(DEPTH)) | pop;
  assign push      = bus.in_valid & pipe_en;

  // Head presentation: zero when empty, so the flags below must also be
  // qualified with out_valid (all-zero data would otherwise look like +0).
  assign head      = out_valid ? mem[rd_ptr_reg] : 32'h0;
  assign head_exp  = head[30:23];
  assign head_mant = head[22:0];

  assign bus.pipe_en     = pipe_en;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = head;
  assign bus.out_is_zero = out_valid & (head_exp == 8'h00) & (head_mant == 23'h0);
  assign bus.out_is_inf  = out_valid & (head_exp == 8'hFF) & (head_mant == 23'h0);
  assign bus.out_is_nan  = out_valid & (head_exp == 8'hFF) & (head_mant != 23'h0);
  assign bus.count       = count_reg;
  assign bus.ovf_err     = ovf_reg;

  // Storage write; contents are left unreset, but a reset cycle never writes.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr_reg] <= bus.in_data;
    end
  end

  // Pointers, occupancy and the sticky overflow flag. Pointers wrap naturally
  // because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
      if (bus.in_valid && !pipe_en) begin
        ovf_reg <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fpu_result_drain.sv
// Self-checking bench for fpu_result_drain: directed scenarios followed by a
// random phase, all checked against a queue-based reference model.
module tb_fpu_result_drain;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference model state: queue of stored results plus the sticky overflow.
  logic [31:0] model_q [$];
  logic        model_ovf = 1'b0;

  fpu_result_drain_if #(.DEPTH(DEPTH)) bus ();

  fpu_result_drain #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Classify a float by its IEEE-754 fields: 0 none, 1 zero, 2 inf, 3 nan.
  function automatic int classify(input logic [31:0] f);
    int e;
    int m;
    e = int'(f[30:23]);
    m = int'(f[22:0]);
    if (e == 0 && m == 0) return 1;
    if (e == 255 && m == 0) return 2;
    if (e == 255) return 3;
    return 0;
  endfunction

  // One clock of stimulus: drive inputs, check all outputs against the model,
  // then advance the model as the clock edge will advance the DUT.
  task automatic step(input logic v, input logic [31:0] d, input logic r);
    int          n;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_pe;
    logic        exp_pop;
    int          cls;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
    n         = model_q.size();
    exp_valid = (n > 0);
    exp_data  = exp_valid ? model_q[0] : 32'h0;
    exp_pop   = exp_valid && r;
    exp_pe    = (n < DEPTH) || exp_pop;
    cls       = exp_valid ? classify(exp_data) : 0;

    checks++;
    assert (bus.count === 3'(n)) else begin
      errors++;
      $error("FAIL count: got %0d want %0d", bus.count, n);
    end
    checks++;
    assert (bus.out_valid === exp_valid) else begin
      errors++;
      $error("FAIL out_valid: got %b want %b", bus.out_valid, exp_valid);
    end
    checks++;
    assert (bus.out_data === exp_data) else begin
      errors++;
      $error("FAIL out_data: got %h want %h", bus.out_data, exp_data);
    end
    checks++;
    assert (bus.pipe_en === exp_pe) else begin
      errors++;
      $error("FAIL pipe_en: got %b want %b", bus.pipe_en, exp_pe);
    end
    checks++;
    assert ({bus.out_is_zero, bus.out_is_inf, bus.out_is_nan} ===
            {cls == 1, cls == 2, cls == 3}) else begin
      errors++;
      $error("FAIL flags: got zin=%b%b%b want class %0d", bus.out_is_zero,
             bus.out_is_inf, bus.out_is_nan, cls);
    end
    checks++;
    assert (bus.ovf_err === model_ovf) else begin
      errors++;
      $error("FAIL ovf_err: got %b want %b", bus.ovf_err, model_ovf);
    end

    $display("cyc %0d: in_valid=%b in_data=%h out_ready=%b | count=%0d out_valid=%b out_data=%h pipe_en=%b ovf=%b",
             cycle, v, d, r, bus.count, bus.out_valid, bus.out_data, bus.pipe_en, bus.ovf_err);

    if (exp_pop) void'(model_q.pop_front());
    if (v && exp_pe) model_q.push_back(d);
    if (v && !exp_pe) model_ovf = 1'b1;
    cycle++;
  endtask

  // Reset for one clock with a (to-be-ignored) result offered on in_valid.
  task automatic do_reset(input logic v, input logic [31:0] d);
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    $display("cyc %0d: reset applied (in_valid=%b in_data=%h)", cycle, v, d);
    cycle++;
  endtask

  initial begin
    logic [31:0] specials [6];
    specials[0] = 32'h7F800000;
    specials[1] = 32'hFFC00001;
    specials[2] = 32'h80000000;
    specials[3] = 32'h00000000;
    specials[4] = 32'h00000001;
    specials[5] = 32'hFF800000;

    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.out_ready = 1'b0;

    // Reset then idle.
    do_reset(1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);

    // Single push with downstream ready: visible next cycle, gone after.
    step(1'b1, 32'h3F800000, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Fill with out_ready low, then a 5th push is dropped and flags overflow.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h1000 + i, 1'b0);
    step(1'b1, 32'hDEADBEEF, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Full FIFO streaming at full rate across pointer wrap.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h2000 + i, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h3000 + i, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

    // Class flags at the head, one per cycle.
    step(1'b1, 32'h7F800000, 1'b0);
    step(1'b1, 32'hFFC00001, 1'b0);
    step(1'b1, 32'h80000000, 1'b0);
    step(1'b1, 32'h00400000, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

    // Reset with three entries held and a result offered during reset.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h4000 + i, 1'b0);
    do_reset(1'b1, 32'hCAFEF00D);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Random traffic with occasional IEEE special values.
    for (int i = 0; i < 400; i++) begin
      logic        v;
      logic [31:0] d;
      logic        r;
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      r = ($urandom_range(0, 2) != 0);
      if (i == 200) do_reset(1'b1, d);
      step(v, d, r);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
